// File: rtl/counter_sequence_checker_pkg.sv
// Shared definitions for the counter sequence checker: FSM state encoding
// and default widths. Optional error counter macro: SEQ_CHK_ERR_CNT_EN.
package counter_seq_pkg;

    // Default observed-count width (states 0..7)
    localparam int DEF_CNT_W     = 3;
    // Default error-counter width
    localparam int DEF_ERR_CNT_W = 8;

    // FSM encoding; the numeric values are visible on the debug state output
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRST     = 3'd1,
        LOCK_UP   = 3'd2,
        LOCK_DOWN = 3'd3,
        ERROR     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/counter_sequence_checker_if.sv
// Bus between a counter observer (master) and the sequence checker (slave).
// Optional error counter macro: SEQ_CHK_ERR_CNT_EN (err_cnt reads 0 otherwise).
interface counter_sequence_checker_if
    import counter_seq_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
);

    logic                 in_valid;
    logic [CNT_W-1:0]     in_count;
    logic                 locked;
    logic                 dir;
    logic                 err;
    logic                 dir_chg;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [2:0]           state;

    modport master (
        output in_valid,
        output in_count,
        input  locked,
        input  dir,
        input  err,
        input  dir_chg,
        input  err_cnt,
        input  state
    );

    modport slave (
        input  in_valid,
        input  in_count,
        output locked,
        output dir,
        output err,
        output dir_chg,
        output err_cnt,
        output state
    );

endinterface

// File: rtl/counter_sequence_checker_step_cmp.sv
// Combinational step classifier: decides whether the new count is one above
// or one below the previous count, with modulo-2^CNT_W wrap-around.
module seq_step_cmp #(
    parameter int CNT_W = 3
) (
    input  logic [CNT_W-1:0] i_prev,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_inc,
    output logic             o_dec
);

    logic [CNT_W-1:0] w_prevPlus;
    logic [CNT_W-1:0] w_prevMinus;

    // Neighbours of the previous count; the fixed width gives the wrap for free
    assign w_prevPlus  = i_prev + CNT_W'(1);
    assign w_prevMinus = i_prev - CNT_W'(1);

    // A repeated count matches neither neighbour, so it is neither inc nor dec
    assign o_inc = (i_count == w_prevPlus);
    assign o_dec = (i_count == w_prevMinus);

endmodule

// File: rtl/counter_sequence_checker.sv
// Watches the output of an up/down counter, locks onto its direction and
// flags any step that is not +1/-1 while locked.
// Optional feature macro: SEQ_CHK_ERR_CNT_EN enables the saturating error
// counter; without it err_cnt is tied to zero and no counter flops exist.
module counter_sequence_checker
    import counter_seq_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    counter_sequence_checker_if.slave  bus
);

    seq_state_t       r_state;
    seq_state_t       w_stateNext;
    logic [CNT_W-1:0] r_prev;
    logic             r_err;
    logic             r_dirChg;
    logic             w_errNext;
    logic             w_dirChgNext;
    logic             w_inc;
    logic             w_dec;

    seq_step_cmp #(
        .CNT_W (CNT_W)
    ) u_stepCmp (
        .i_prev  (r_prev),
        .i_count (bus.in_count),
        .o_inc   (w_inc),
        .o_dec   (w_dec)
    );

    // Next-state and pulse decode; an invalid cycle holds state and drops pulses
    always_comb begin
        w_stateNext  = r_state;
        w_errNext    = 1'b0;
        w_dirChgNext = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                IDLE, ERROR: begin
                    w_stateNext = FIRST;
                end
                FIRST: begin
                    if (w_inc) begin
                        w_stateNext = LOCK_UP;
                    end else if (w_dec) begin
                        w_stateNext = LOCK_DOWN;
                    end
                end
                LOCK_UP: begin
                    if (w_inc) begin
                        w_stateNext = LOCK_UP;
                    end else if (w_dec) begin
                        w_stateNext  = LOCK_DOWN;
                        w_dirChgNext = 1'b1;
                    end else begin
                        w_stateNext = ERROR;
                        w_errNext   = 1'b1;
                    end
                end
                LOCK_DOWN: begin
                    if (w_dec) begin
                        w_stateNext = LOCK_DOWN;
                    end else if (w_inc) begin
                        w_stateNext  = LOCK_UP;
                        w_dirChgNext = 1'b1;
                    end else begin
                        w_stateNext = ERROR;
                        w_errNext   = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // State, previous sample and pulse registers; reset wins over any step
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_prev   <= '0;
            r_err    <= 1'b0;
            r_dirChg <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_err    <= w_errNext;
            r_dirChg <= w_dirChgNext;
            if (bus.in_valid) begin
                r_prev <= bus.in_count;
            end
        end
    end

    assign bus.state   = r_state;
    assign bus.locked  = (r_state == LOCK_UP) || (r_state == LOCK_DOWN);
    assign bus.dir     = (r_state == LOCK_UP);
    assign bus.err     = r_err;
    assign bus.dir_chg = r_dirChg;

`ifdef SEQ_CHK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_errCnt;

    // Count every error pulse as it is registered, sticking at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_errCnt <= '0;
        end else if (w_errNext && (r_errCnt != {ERR_CNT_W{1'b1}})) begin
            r_errCnt <= r_errCnt + ERR_CNT_W'(1);
        end
    end

    assign bus.err_cnt = r_errCnt;
`else
    assign bus.err_cnt = {ERR_CNT_W{1'b0}};
`endif

endmodule
